// File: rtl/spi_resp_pkg.sv
// Shared types and frame constants for the SPI register responder.
package spi_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int unsigned FRAME_LEN = 16;
    // Position of the R/W flag within the frame, counted from the first bit sent.
    localparam int unsigned RW_BIT    = 0;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

endpackage

// File: rtl/spi_resp_sync.sv
// Two-flop synchroniser with rising/falling edge detection on the synchronised level.
module spi_resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI-mode-0 register-file responder: 16-bit frames (R/W, 7-bit address, 8-bit data).
// Optional: define SPI_RESP_RO_PROTECT_EN to reject writes at or above RO_BASE.
module spi_responder
    import spi_resp_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 7,
    parameter int unsigned       DATA_W  = 8,
    parameter logic [ADDR_W-1:0] RO_BASE = 7'h60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_CLK_LINE,
    input  logic              SPI_EN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_rdata,
    output logic              frame_done,
    output logic              frame_err,
    output logic [2:0]        cur_state
);

    localparam int unsigned      CMD_LEN    = FRAME_LEN - DATA_W;
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
`ifdef SPI_RESP_RO_PROTECT_EN
    localparam bit RoProtect = 1'b1;
`else
    localparam bit RoProtect = 1'b0;
`endif

    logic sclk_s, sclk_rise, sclk_fall;
    logic en_s, en_rise, en_fall;
    logic mosi_meta_q, mosi_s_q;

    spi_resp_sync u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (SPI_CLK_LINE),
        .q_o    (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_resp_sync u_sync_en (
        .clk    (clk),
        .rst    (rst),
        .d_i    (SPI_EN),
        .q_o    (en_s),
        .rise_o (en_rise),
        .fall_o (en_fall)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   word;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                miso_q, miso_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                we;
    logic                wr_blocked;
    logic [1:0]          warm_q;
    logic                armed_q;
    logic [DATA_W-1:0]   regs_q [2**ADDR_W];
    logic [DATA_W-1:0]   host_rdata_q;

    assign word       = {shift_q, mosi_s_q};
    assign wr_blocked = RoProtect && (addr_q >= RO_BASE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        miso_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (armed_q && en_rise && !sclk_s) state_d = ST_CMD;
            end
            ST_CMD, ST_WR, ST_RD: begin
                if (en_fall) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    if (state_q == ST_RD) begin
                        miso_d = miso_q;
                        if (sclk_fall) begin
                            miso_d = rd_q[DATA_W-1];
                            rd_d   = rd_q << 1;
                        end
                    end
                    if (sclk_rise) begin
                        shift_d = word[DATA_W-2:0];
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CMD_LAST) begin
                            addr_d  = word[ADDR_W-1:0];
                            rd_d    = regs_q[addr_d];
                            state_d = word[CMD_LEN-1-RW_BIT] ? ST_WR : ST_RD;
                        end else if (cnt_q == FRAME_LAST) begin
                            state_d = ST_DONE;
                            miso_d  = 1'b0;
                            if (state_q == ST_WR && wr_blocked) begin
                                err_d = 1'b1;
                            end else begin
                                we     = (state_q == ST_WR);
                                done_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!en_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A frame already running when reset lifts is skipped: arm only once EN is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            rd_q        <= '0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            warm_q      <= '0;
            armed_q     <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mosi_meta_q <= SPI_MOSI;
            mosi_s_q    <= mosi_meta_q;
            if (warm_q != 2'd3) warm_q <= warm_q + 1'b1;
            if (warm_q == 2'd3 && !en_s) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
            host_rdata_q <= '0;
        end else begin
            if (we) regs_q[addr_q] <= word;
            host_rdata_q <= regs_q[host_addr];
        end
    end

    assign SPI_MISO   = miso_q;
    assign host_rdata = host_rdata_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign cur_state  = state_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder with a frame-level register model.
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SPI_CLK_LINE = 1'b0;
    logic       SPI_EN = 1'b0;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic [6:0] host_addr = '0;
    logic [7:0] host_rdata;
    logic       frame_done;
    logic       frame_err;
    logic [2:0] cur_state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;

    logic [7:0]  model [128];
    bit          chk_en   = 1'b0;
    bit          chk_prev = 1'b0;
    bit          pin_en   = 1'b0;
    logic [6:0]  pin_addr = '0;
    logic [15:0] rst_fr   = 16'h9EAA;
    int          d0, e0;

    spi_responder #(
        .ADDR_W  (7),
        .DATA_W  (8),
        .RO_BASE (7'h60)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .SPI_CLK_LINE (SPI_CLK_LINE),
        .SPI_EN       (SPI_EN),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_MISO     (SPI_MISO),
        .host_addr    (host_addr),
        .host_rdata   (host_rdata),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .cur_state    (cur_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse counters, idle-time comparison against the model, and host address driver.
    always @(negedge clk) begin
        if (frame_done === 1'b1) n_done++;
        if (frame_err === 1'b1) n_err++;
        if (chk_en && chk_prev) begin
            check("idle_rdata", host_rdata, model[host_addr]);
            check("idle_state", cur_state, 0);
            check("idle_miso", SPI_MISO, 0);
            check("idle_done", frame_done, 0);
            check("idle_err", frame_err, 0);
        end
        chk_prev = chk_en;
        host_addr = pin_en ? pin_addr : 7'($urandom_range(0, 127));
    end

    task automatic spi_bit(input bit b, output bit miso_pre);
        SPI_MOSI = b;
        repeat (5) @(negedge clk);
        miso_pre = SPI_MISO;
        SPI_CLK_LINE = 1'b1;
        repeat (4) @(negedge clk);
        SPI_CLK_LINE = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [15:0] fr, input int nbits);
        logic [7:0] got;
        logic [2:0] st;
        logic [6:0] a;
        logic [7:0] dat;
        bit         b, bin, wr, blocked;
        int         dd, de;
        chk_en = 1'b0;
        dd = n_done;
        de = n_err;
        got = '0;
        SPI_EN = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bin = (i < 16) ? fr[15 - i] : 1'b1;
            spi_bit(bin, b);
            if (i >= 8 && i < 16) got = {got[6:0], b};
        end
        repeat (4) @(negedge clk);
        st = cur_state;
        SPI_EN = 1'b0;
        repeat (8) @(negedge clk);
        wr = fr[15];
        a = fr[14:8];
        dat = fr[7:0];
        blocked = 1'b0;
`ifdef SPI_RESP_RO_PROTECT_EN
        blocked = (a >= 7'h60);
`endif
        if (nbits < 16) begin
            check({name, "_abort_err"}, n_err - de, 1);
            check({name, "_abort_done"}, n_done - dd, 0);
            check({name, "_abort_state"}, cur_state, 0);
        end else begin
            check({name, "_state_done"}, st, 4);
            if (wr && !blocked) model[a] = dat;
            check({name, "_done"}, n_done - dd, (wr && blocked) ? 0 : 1);
            check({name, "_err"}, n_err - de, (wr && blocked) ? 1 : 0);
            if (!wr) check({name, "_miso"}, got, model[a]);
        end
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pin_read(input string name, input logic [6:0] a, input logic [7:0] exp_lit);
        pin_addr = a;
        pin_en = 1'b1;
        repeat (3) @(negedge clk);
        check(name, host_rdata, exp_lit);
        check({name, "_model"}, model[a], exp_lit);
        pin_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_miso"}, SPI_MISO, 0);
        check({name, "_done"}, frame_done, 0);
        check({name, "_err"}, frame_err, 0);
        check({name, "_rdata"}, host_rdata, 0);
        check({name, "_state"}, cur_state, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        run_frame("wr1e", 16'h9E3C, 16);
        pin_read("rd1e_host", 7'h1E, 8'h3C);

        run_frame("rd1e", 16'h1E00, 16);
        pin_read("rd1e_keep", 7'h1E, 8'h3C);

        run_frame("abort5", 16'h8A77, 5);
        pin_read("abort_keep", 7'h0A, 8'h00);
        run_frame("wr0a", 16'h8A77, 16);
        pin_read("wr0a_host", 7'h0A, 8'h77);

        run_frame("wr5f", 16'hDF11, 16);
        pin_read("wr5f_host", 7'h5F, 8'h11);
        run_frame("wr60", 16'hE055, 16);
`ifdef SPI_RESP_RO_PROTECT_EN
        pin_read("wr60_host", 7'h60, 8'h00);
`else
        pin_read("wr60_host", 7'h60, 8'h55);
`endif

        run_frame("wr05_x20", 16'h85C3, 20);
        pin_read("wr05_host", 7'h05, 8'hC3);
        run_frame("rd05_x20", 16'h0500, 20);

        chk_en = 1'b0;
        d0 = n_done;
        e0 = n_err;
        SPI_EN = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) spi_bit(rst_fr[15 - i], b);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        for (int i = 10; i < 16; i++) spi_bit(rst_fr[15 - i], b);
        repeat (4) @(negedge clk);
        check("midrst_ignored_state", cur_state, 0);
        SPI_EN = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_done", n_done - d0, 0);
        check("midrst_no_err", n_err - e0, 0);
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        pin_read("midrst_1e", 7'h1E, 8'h00);
        pin_read("midrst_05", 7'h05, 8'h00);

        run_frame("wr1e_after", 16'h9E5A, 16);
        pin_read("wr1e_after_host", 7'h1E, 8'h5A);
        run_frame("rd1e_after", 16'h1E00, 16);

        chk_en = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
